// File: rtl/fbcpu_mem_responder_if.sv
// CPU bus and program-download port between the FBCPU top level and its memory responder.
// master drives CPU accesses and downloads; slave is the responder.
interface fbcpu_mem_responder_if #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 10
);
  logic [ADDRESS_WIDTH-1:0] MAR;
  logic [DATA_WIDTH-1:0]    MDRIn;
  logic                     RAMWr;
  logic [DATA_WIDTH-1:0]    MDROut;
  logic                     ld_start;
  logic                     ld_valid;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic                     cpu_hold;
  logic                     ld_done;
  logic                     ld_err;
  logic [ADDRESS_WIDTH:0]   ld_words;

  modport master (
    output MAR, MDRIn, RAMWr, ld_start, ld_valid, ld_data, ld_last,
    input  MDROut, ld_ready, cpu_hold, ld_done, ld_err, ld_words
  );

  modport slave (
    input  MAR, MDRIn, RAMWr, ld_start, ld_valid, ld_data, ld_last,
    output MDROut, ld_ready, cpu_hold, ld_done, ld_err, ld_words
  );
endinterface

// File: rtl/fbcpu_mem_responder.sv
// FBCPU memory responder: synchronous RAM that wipes itself after reset and accepts program
// downloads while holding the CPU in reset.
module fbcpu_mem_responder #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  fbcpu_mem_responder_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(Depth - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PtrOne   = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   WordsOne = (ADDRESS_WIDTH + 1)'(1);

  localparam logic [1:0] StClear = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] load_ptr_q, load_ptr_d;
  logic [DATA_WIDTH-1:0]    mdr_out_q, mdr_out_d;
  logic                     cpu_hold_q, cpu_hold_d;
  logic                     ld_ready_q, ld_ready_d;
  logic                     ld_done_q, ld_done_d;
  logic                     ld_err_q, ld_err_d;
  logic [ADDRESS_WIDTH:0]   ld_words_q, ld_words_d;

  logic [DATA_WIDTH-1:0]    mem_q [Depth];
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     accept;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    load_ptr_d = load_ptr_q;
    mdr_out_d  = '0;
    ld_done_d  = 1'b0;
    ld_err_d   = ld_err_q;
    ld_words_d = ld_words_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.MAR;
    mem_wdata  = bus.MDRIn;
    accept     = (state_q == StLoad) && ld_ready_q && bus.ld_valid;

    case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + PtrOne;
        if (clr_ptr_q == LastAddr) state_d = StRun;
      end
      StRun: begin
        // Read sees the pre-write contents on a same-address write.
        mdr_out_d = mem_q[bus.MAR];
        mem_we    = bus.RAMWr;
        if (bus.ld_start) begin
          state_d    = StLoad;
          load_ptr_d = '0;
          ld_words_d = '0;
          ld_err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we     = 1'b1;
          mem_waddr  = load_ptr_q;
          mem_wdata  = bus.ld_data;
          load_ptr_d = load_ptr_q + PtrOne;
          ld_words_d = ld_words_q + WordsOne;
          if (bus.ld_last || (load_ptr_q == LastAddr)) begin
            state_d   = StRun;
            ld_done_d = 1'b1;
            if (!bus.ld_last) ld_err_d = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase

    cpu_hold_d = (state_d != StRun);
    ld_ready_d = (state_d == StLoad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      load_ptr_q <= '0;
      mdr_out_q  <= '0;
      cpu_hold_q <= 1'b1;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_words_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      load_ptr_q <= load_ptr_d;
      mdr_out_q  <= mdr_out_d;
      cpu_hold_q <= cpu_hold_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
      ld_words_q <= ld_words_d;
    end
  end

  // Array has no reset of its own; CLEAR wipes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.MDROut   = mdr_out_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_err   = ld_err_q;
  assign bus.ld_words = ld_words_q;

endmodule

// File: tb/tb_fbcpu_mem_responder.sv
// Scoreboard bench for fbcpu_mem_responder: stimulus queues expected reads and download
// completions, monitors pop and compare when the responder presents them.
module tb_fbcpu_mem_responder;

  typedef struct {
    logic [6:0] words;
    logic       err;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_chk = 1'b0;
  logic rd_pend = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] rd_q[$];
  done_t      done_q[$];

  fbcpu_mem_responder_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) bus ();

  fbcpu_mem_responder #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read monitor: a read issued before an edge is due on MDROut after that edge.
  always @(posedge clk) rd_pend <= rd_chk;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
      else chk("MDROut", 32'(bus.MDROut), 32'(rd_q.pop_front()));
    end
  end

  // Completion monitor: every ld_done cycle must match one queued download.
  always @(negedge clk) begin
    if (bus.ld_done) begin
      if (done_q.size() == 0) begin
        chk("ld_done_unexpected", 32'd1, 32'd0);
      end else begin
        done_t e;
        e = done_q.pop_front();
        chk("done_ld_words", 32'(bus.ld_words), 32'(e.words));
        chk("done_ld_err", 32'(bus.ld_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [5:0] a, input logic [9:0] d, input logic we,
                     input logic c, input logic [9:0] exp);
    bus.MAR   = a;
    bus.MDRIn = d;
    bus.RAMWr = we;
    rd_chk    = c;
    if (c) rd_q.push_back(exp);
    tick();
    bus.RAMWr = 1'b0;
    rd_chk    = 1'b0;
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic ld_word(input logic [9:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Counts hold cycles from the negedge after the reset edge until cpu_hold drops.
  task automatic wait_clear(input string name, input int exp_cnt);
    int cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.cpu_hold) break;
      cnt++;
      chk("clear_MDROut", 32'(bus.MDROut), 32'd0);
      chk("clear_ld_ready", 32'(bus.ld_ready), 32'd0);
    end
    chk(name, 32'(cnt), 32'(exp_cnt));
  endtask

  initial begin
    done_t d;
    bus.MAR = '0; bus.MDRIn = '0; bus.RAMWr = 1'b0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;

    // Power-on reset pulse of one cycle.
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ld_words", 32'(bus.ld_words), 32'd0);
    chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
    chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
    wait_clear("poweron_hold_cycles", 64);

    // Write then read, 1-cycle latency.
    cpu(6'd5, 10'h2A5, 1'b1, 1'b0, 10'h000);
    cpu(6'd5, 10'h000, 1'b0, 1'b1, 10'h2A5);
    @(negedge clk);

    // Read-during-write returns old data.
    cpu(6'd9, 10'h011, 1'b1, 1'b0, 10'h000);
    cpu(6'd9, 10'h3FF, 1'b1, 1'b1, 10'h011);
    cpu(6'd9, 10'h000, 1'b0, 1'b1, 10'h3FF);
    @(negedge clk);

    // Preload nonzero, pulse reset, memory must be wiped.
    cpu(6'd0, 10'h155, 1'b1, 1'b0, 10'h000);
    cpu(6'd31, 10'h2AA, 1'b1, 1'b0, 10'h000);
    cpu(6'd63, 10'h3C3, 1'b1, 1'b0, 10'h000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("rst_hold_cycles", 64);
    cpu(6'd0, 10'h000, 1'b0, 1'b1, 10'h000);
    cpu(6'd31, 10'h000, 1'b0, 1'b1, 10'h000);
    cpu(6'd63, 10'h000, 1'b0, 1'b1, 10'h000);
    @(negedge clk);

    // Download of three words with a stall and an ignored CPU write.
    cpu(6'd1, 10'h155, 1'b1, 1'b0, 10'h000);
    d.words = 7'd3; d.err = 1'b0; done_q.push_back(d);
    start_load();
    chk("load_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("load_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    ld_word(10'h00A, 1'b0);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b1; bus.ld_data = 10'h3FF;
    cpu(6'd1, 10'h3AA, 1'b1, 1'b1, 10'h000);
    bus.ld_last = 1'b0;
    ld_word(10'h1C3, 1'b0);
    ld_word(10'h2FF, 1'b1);
    chk("load_end_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("load_end_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    cpu(6'd0, 10'h000, 1'b0, 1'b1, 10'h00A);
    cpu(6'd1, 10'h000, 1'b0, 1'b1, 10'h1C3);
    cpu(6'd2, 10'h000, 1'b0, 1'b1, 10'h2FF);
    chk("load_ld_words_hold", 32'(bus.ld_words), 32'd3);

    // Overflow: 64 words, no ld_last.
    d.words = 7'd64; d.err = 1'b1; done_q.push_back(d);
    start_load();
    for (int i = 0; i < 64; i++) begin
      chk("ovf_ld_ready", 32'(bus.ld_ready), 32'd1);
      ld_word(10'h100 + 10'(i), 1'b0);
    end
    chk("ovf_end_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("ovf_end_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("ovf_ld_words", 32'(bus.ld_words), 32'd64);
    chk("ovf_ld_err", 32'(bus.ld_err), 32'd1);
    cpu(6'd0, 10'h000, 1'b0, 1'b1, 10'h100);
    cpu(6'd63, 10'h000, 1'b0, 1'b1, 10'h13F);
    cpu(6'd1, 10'h000, 1'b0, 1'b1, 10'h101);
    d.words = 7'd1; d.err = 1'b0; done_q.push_back(d);
    start_load();
    chk("restart_ld_err", 32'(bus.ld_err), 32'd0);
    chk("restart_ld_words", 32'(bus.ld_words), 32'd0);
    ld_word(10'h0AB, 1'b1);
    cpu(6'd0, 10'h000, 1'b0, 1'b1, 10'h0AB);
    @(negedge clk);

    // Reset mid-load: abort, re-clear, no ld_done, ld_start ignored in CLEAR.
    start_load();
    ld_word(10'h111, 1'b0);
    ld_word(10'h222, 1'b0);
    rst = 1'b1;
    bus.ld_start = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("midload_hold_cycles", 64);
    bus.ld_start = 1'b0;
    cpu(6'd0, 10'h000, 1'b0, 1'b1, 10'h000);
    cpu(6'd1, 10'h000, 1'b0, 1'b1, 10'h000);
    chk("midload_ld_ready", 32'(bus.ld_ready), 32'd0);

    repeat (3) tick();
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
